// File: rtl/enc_burst_reader_if.sv
// Handshake and memory bus between a requesting FSM, the burst reader and
// the encrypted memory.
interface enc_burst_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6
);
    logic              start;
    logic [ADDR_W-1:0] fsm_adr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              finish;
    logic [ADDR_W-1:0] enc_adr;
    logic [DATA_W-1:0] enc_data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [LEN_W-1:0]  out_idx;

    modport slave (
        input  start, fsm_adr, len, enc_data_in,
        output busy, finish, enc_adr, data_out, data_valid, out_idx
    );

    modport master (
        output start, fsm_adr, len, enc_data_in,
        input  busy, finish, enc_adr, data_out, data_valid, out_idx
    );
endinterface

// File: rtl/enc_burst_reader.sv
// Reads a burst of consecutive words from a fixed-latency encrypted memory and
// hands each word, tagged with its burst offset, to the requesting FSM.
module enc_burst_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    enc_burst_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [2:0]        lat_q, lat_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;
    logic [ADDR_W-1:0] enc_adr_q, enc_adr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic [LEN_W-1:0]  out_idx_q, out_idx_d;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lat_d        = lat_q;
        busy_d       = busy_q;
        finish_d     = 1'b0;
        enc_adr_d    = enc_adr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        out_idx_d    = out_idx_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // The finish cycle still counts as busy, so a new request is
                // taken only once the finish pulse has gone.
                if (bus.start && !finish_q) begin
                    base_d  = bus.fsm_adr;
                    cnt_d   = bus.len;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                enc_adr_d = base_q + ADDR_W'(idx_q);
                lat_d     = LAT_M1;
                state_d   = (RD_LAT > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) state_d = CAPTURE;
            end
            CAPTURE: begin
                data_out_d   = bus.enc_data_in;
                out_idx_d    = idx_q;
                data_valid_d = 1'b1;
                idx_d        = idx_q + LEN_W'(1);
                state_d      = (idx_d == cnt_q) ? DONE : ISSUE;
            end
            DONE: begin
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            lat_q        <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            enc_adr_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            out_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            enc_adr_q    <= enc_adr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            out_idx_q    <= out_idx_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.finish     = finish_q;
    assign bus.enc_adr    = enc_adr_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.out_idx    = out_idx_q;
endmodule
